// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI mode-0 slave receive front end.
//
// Contents:
//   DEFAULT_DATA_W - default bits per SPI word
//   rx_state_e     - receive state machine encoding
//   rx_entry_t     - layout of one receive FIFO entry at the default width
//   maj3           - three-input majority vote, used by the optional
//                    glitch filter (SPI_SLAVE_RX_GLITCH_FILTER_EN)
package spi_rx_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } rx_state_e;

    // The FIFO stores {sof, data}; sof sits above the data bits.
    typedef struct packed {
        logic                      sof;
        logic [DEFAULT_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// Receive stream interface between spi_slave_rx and downstream logic.
//
// Signals:
//   rx_data  - word at the FIFO head
//   rx_sof   - head word is the first word of its frame
//   rx_valid - head word is valid
//   rx_ready - downstream accepts the head word (pop on valid & ready)
// Modports:
//   master - the receiver (drives data/sof/valid)
//   slave  - the consumer (drives ready)
interface spi_slave_rx_if
    import spi_rx_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_sof;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_sof,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_sof,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous receive FIFO with a registered head word.
//
// The head register always holds the oldest stored entry, so the entry count
// includes the word being presented. A push into a full FIFO is still taken
// when a pop happens in the same cycle; otherwise it is dropped and drop_o
// pulses. A pop on an empty FIFO is ignored.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   push_i       - write push_data_i
//   push_data_i  - entry to write
//   pop_i        - consumer ready; pops when the head is valid
//   head_o       - registered head entry
//   head_valid_o - head entry is valid
//   drop_o       - push rejected because the FIFO was full
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_W + 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             head_valid_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d, count_after_pop;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full, empty, pop, push_ok;

    // Pointer/count bookkeeping and next head selection. When the FIFO would
    // otherwise be empty after this cycle's pop, the incoming word goes
    // straight into the head register; otherwise the head is read from the
    // entry the read pointer will point at.
    always_comb begin
        empty           = (count_q == '0);
        full            = (count_q == CW'(DEPTH));
        pop             = pop_i && !empty;
        push_ok         = push_i && (!full || pop);
        drop_o          = push_i && !push_ok;
        count_after_pop = count_q - CW'(pop);
        count_d         = count_after_pop + CW'(push_ok);
        rd_ptr_d        = rd_ptr_q + AW'(pop);
        wr_ptr_d        = wr_ptr_q + AW'(push_ok);
        mem_d           = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
        end
        if (push_ok && (count_after_pop == '0)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        valid_d = (count_d != '0);
    end

    // Control state; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o       = head_q;
    assign head_valid_o = valid_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave receive front end.
//
// SCLK, SS and MOSI are oversampled in the clk domain through equal-length
// synchronisers, MSB-first words are assembled and pushed with a
// start-of-frame flag into spi_rx_fifo, which presents them on the rx stream.
//
// Ports:
//   clk, rst        - system clock (>= 4x SCLK), synchronous active-high reset
//   spi_clk_i       - SPI SCLK pin (asynchronous)
//   spi_ss_i        - SPI slave select pin, active low (asynchronous)
//   mosi_i          - SPI data in pin (asynchronous)
//   rx              - receive stream (spi_slave_rx_if.master)
//   frame_active_o  - SS asserted and a frame is being received
//   overrun_o       - sticky: a word was dropped on a full FIFO
//   ovr_clr_i       - clears overrun_o (a new overrun in the same cycle wins)
//   bit_err_o       - one-cycle pulse: frame ended on a partial word
//
// Optional build macro SPI_SLAVE_RX_GLITCH_FILTER_EN: SCLK and SS pass through
// a 3-sample majority filter (+2 clk) before edge detection so single-clk
// pulses are rejected; clk must then be >= 6x SCLK. MOSI is delayed by the
// same 2 clk to stay aligned with the filtered SCLK.
module spi_slave_rx
    import spi_rx_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_clk_i,
    input  logic           spi_ss_i,
    input  logic           mosi_i,
    spi_slave_rx_if.master rx,
    output logic           frame_active_o,
    output logic           overrun_o,
    input  logic           ovr_clr_i,
    output logic           bit_err_o
);
    localparam int BCW = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_raw, ss_raw, mosi_raw;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
    logic sclk_rise, ss_fall, ss_rise;

    rx_state_e         state_q, state_d;
    // Only the first DATA_W-1 bits of a word are ever held here; the last
    // bit is taken straight from MOSI into the pushed entry.
    logic [DATA_W-2:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              sof_pend_q, sof_pend_d;
    logic              bit_err_q, bit_err_d;
    logic              overrun_q, overrun_d;
    logic              push;
    logic [DATA_W:0]   push_word;
    logic [DATA_W:0]   head;
    logic              fifo_drop;

    // Input synchronisers: every pin sees the same number of flops so the
    // relative timing of SCLK and MOSI is preserved.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sclk_raw    = sclk_sync_q[SYNC_STAGES-1];
        ss_raw      = ss_sync_q[SYNC_STAGES-1];
        mosi_raw    = mosi_sync_q[SYNC_STAGES-1];
    end

`ifdef SPI_SLAVE_RX_GLITCH_FILTER_EN
    logic [1:0] sclk_hist_q, sclk_hist_d, ss_hist_q, ss_hist_d, mosi_dly_q, mosi_dly_d;
    logic       sclk_filt_q, sclk_filt_d, ss_filt_q, ss_filt_d;

    // Majority of the current and two previous samples, registered; a level
    // must persist for two samples to pass, so a lone 1-clk pulse is lost.
    always_comb begin
        sclk_hist_d = {sclk_hist_q[0], sclk_raw};
        ss_hist_d   = {ss_hist_q[0], ss_raw};
        mosi_dly_d  = {mosi_dly_q[0], mosi_raw};
        sclk_filt_d = maj3(sclk_raw, sclk_hist_q[0], sclk_hist_q[1]);
        ss_filt_d   = maj3(ss_raw, ss_hist_q[0], ss_hist_q[1]);
        sclk_s      = sclk_filt_q;
        ss_s        = ss_filt_q;
        mosi_s      = mosi_dly_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_hist_q <= '0;
            ss_hist_q   <= '0;
            mosi_dly_q  <= '0;
            sclk_filt_q <= 1'b0;
            ss_filt_q   <= 1'b0;
        end else begin
            sclk_hist_q <= sclk_hist_d;
            ss_hist_q   <= ss_hist_d;
            mosi_dly_q  <= mosi_dly_d;
            sclk_filt_q <= sclk_filt_d;
            ss_filt_q   <= ss_filt_d;
        end
    end
`else
    always_comb begin
        sclk_s = sclk_raw;
        ss_s   = ss_raw;
        mosi_s = mosi_raw;
    end
`endif

    // Edge detection on the conditioned SCLK and SS.
    always_comb begin
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        ss_fall     = ~ss_s & ss_prev_q;
        ss_rise     = ss_s & ~ss_prev_q;
    end

    // Receive state machine and shifter. SS rising takes priority over a
    // coincident SCLK edge, which is then ignored. WAIT_IDLE keeps us out of
    // a frame that was already running when reset was released.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sof_pend_d = sof_pend_q;
        bit_err_d  = 1'b0;
        push       = 1'b0;
        push_word  = {sof_pend_q, shreg_q, mosi_s};
        case (state_q)
            WAIT_IDLE: begin
                if (ss_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    sof_pend_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_err_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                        push       = 1'b1;
                        sof_pend_d = 1'b0;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
        overrun_d = fifo_drop ? 1'b1 : (ovr_clr_i ? 1'b0 : overrun_q);
    end

    // State registers for synchronisers, edge detectors, FSM and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            state_q     <= WAIT_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sof_pend_q  <= 1'b0;
            bit_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            sof_pend_q  <= sof_pend_d;
            bit_err_q   <= bit_err_d;
            overrun_q   <= overrun_d;
        end
    end

    spi_rx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_data_i  (push_word),
        .pop_i        (rx.rx_ready),
        .head_o       (head),
        .head_valid_o (rx.rx_valid),
        .drop_o       (fifo_drop)
    );

    assign rx.rx_data     = head[DATA_W-1:0];
    assign rx.rx_sof      = head[DATA_W];
    assign frame_active_o = (state_q == ACTIVE) && !ss_s;
    assign overrun_o      = overrun_q;
    assign bit_err_o      = bit_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed SPI frames driven on the
// pins, expected words queued on a scoreboard and compared as beats leave
// the rx stream.
module tb_spi_slave_rx;
    import spi_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_ss = 1'b1;
    logic mosi = 1'b0;
    logic ovr_clr = 1'b0;
    logic frame_active, overrun, bit_err;

    int passed = 0;
    int total = 0;
    int beat_cnt = 0;
    int bit_err_cnt = 0;
    int bit_err_run = 0;
    int bit_err_run_max = 0;
    rx_entry_t sb[$];
    rx_entry_t mon_exp;

    spi_slave_rx_if #(.DATA_W(8)) rx_if ();

    spi_slave_rx #(
        .DATA_W      (8),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_clk_i      (spi_clk),
        .spi_ss_i       (spi_ss),
        .mosi_i         (mosi),
        .rx             (rx_if),
        .frame_active_o (frame_active),
        .overrun_o      (overrun),
        .ovr_clr_i      (ovr_clr),
        .bit_err_o      (bit_err)
    );

    // 10-unit system clock; SCLK half period is 40 units (clk/8).
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expectWord(input logic sof, input logic [7:0] data);
        rx_entry_t e;
        e.sof  = sof;
        e.data = data;
        sb.push_back(e);
    endtask

    // Stream monitor: every accepted beat is matched against the scoreboard;
    // bit_err pulses are counted and their width tracked.
    always @(negedge clk) begin
        if (!rst && rx_if.rx_valid && rx_if.rx_ready) begin
            beat_cnt++;
            checkOutput("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checkOutput("beat_data", 32'(rx_if.rx_data), 32'(mon_exp.data));
                checkOutput("beat_sof", 32'(rx_if.rx_sof), 32'(mon_exp.sof));
            end
        end
        if (bit_err) begin
            bit_err_cnt++;
            bit_err_run++;
            if (bit_err_run > bit_err_run_max) bit_err_run_max = bit_err_run;
        end else begin
            bit_err_run = 0;
        end
    end

    task automatic spiSelect();
        @(posedge clk);
        #3;
        spi_ss = 1'b0;
        #80;
    endtask

    task automatic spiDeselect();
        #40;
        spi_ss = 1'b1;
        #120;
    endtask

    // Shift nbits of data MSB first; glitch_at inserts a 1-clk SCLK pulse in
    // the low phase before that bit's real rising edge (-1 for none).
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[7-i];
            if (i == glitch_at) begin
                #20 spi_clk = 1'b1;
                #10 spi_clk = 1'b0;
                #10;
            end else begin
                #40;
            end
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
    endtask

    // Bounded wait for the scoreboard to empty, then a quiet window to catch
    // any extra beats.
    task automatic waitDrain(input string tag, input int beats_exp);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_beats"}, 32'(beat_cnt), 32'(beats_exp));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int eb;
        logic [15:0] acc;
        logic [7:0] gword;
        logic [7:0] glitch_word;
        int gbits;

        rx_if.rx_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(rx_if.rx_valid), 32'd0);
        checkOutput("rst_data", 32'(rx_if.rx_data), 32'd0);
        checkOutput("rst_sof", 32'(rx_if.rx_sof), 32'd0);
        checkOutput("rst_frame_active", 32'(frame_active), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_bit_err", 32'(bit_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Test 1: single word 0xA5
        $display("[TB] test 1: single word");
        base = beat_cnt;
        eb = bit_err_cnt;
        expectWord(1'b1, 8'hA5);
        spiSelect();
        @(negedge clk);
        checkOutput("t1_frame_active_on", 32'(frame_active), 32'd1);
        applyStimulus(8'hA5, 8, -1);
        spiDeselect();
        checkOutput("t1_frame_active_off", 32'(frame_active), 32'd0);
        waitDrain("t1", base + 1);
        checkOutput("t1_bit_err", 32'(bit_err_cnt - eb), 32'd0);

        // Test 2: three-word frame then a new single-word frame
        $display("[TB] test 2: multi-word frames");
        base = beat_cnt;
        expectWord(1'b1, 8'h01);
        expectWord(1'b0, 8'h02);
        expectWord(1'b0, 8'h03);
        spiSelect();
        applyStimulus(8'h01, 8, -1);
        applyStimulus(8'h02, 8, -1);
        applyStimulus(8'h03, 8, -1);
        spiDeselect();
        expectWord(1'b1, 8'h10);
        spiSelect();
        applyStimulus(8'h10, 8, -1);
        spiDeselect();
        waitDrain("t2", base + 4);

        // Test 3: overrun with ready low
        $display("[TB] test 3: overrun");
        base = beat_cnt;
        rx_if.rx_ready = 1'b0;
        expectWord(1'b1, 8'h11);
        expectWord(1'b0, 8'h12);
        expectWord(1'b0, 8'h13);
        expectWord(1'b0, 8'h14);
        spiSelect();
        applyStimulus(8'h11, 8, -1);
        applyStimulus(8'h12, 8, -1);
        applyStimulus(8'h13, 8, -1);
        applyStimulus(8'h14, 8, -1);
        checkOutput("t3_overrun_after4", 32'(overrun), 32'd0);
        applyStimulus(8'h15, 8, -1);
        checkOutput("t3_overrun_after5", 32'(overrun), 32'd1);
        applyStimulus(8'h16, 8, -1);
        spiDeselect();
        @(negedge clk);
        checkOutput("t3_head_valid", 32'(rx_if.rx_valid), 32'd1);
        checkOutput("t3_head_data", 32'(rx_if.rx_data), 32'h11);
        checkOutput("t3_head_sof", 32'(rx_if.rx_sof), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("t3_head_stable", 32'(rx_if.rx_data), 32'h11);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        waitDrain("t3", base + 4);
        checkOutput("t3_overrun_sticky", 32'(overrun), 32'd1);
        @(posedge clk);
        #1 ovr_clr = 1'b1;
        @(posedge clk);
        #1 ovr_clr = 1'b0;
        @(negedge clk);
        checkOutput("t3_overrun_cleared", 32'(overrun), 32'd0);

        // Test 4: partial word then a clean frame
        $display("[TB] test 4: partial word");
        base = beat_cnt;
        eb = bit_err_cnt;
        spiSelect();
        applyStimulus(8'hB7, 5, -1);
        spiDeselect();
        checkOutput("t4_bit_err_pulses", 32'(bit_err_cnt - eb), 32'd1);
        checkOutput("t4_bit_err_width", 32'(bit_err_run_max), 32'd1);
        waitDrain("t4_partial", base);
        expectWord(1'b1, 8'h3C);
        spiSelect();
        applyStimulus(8'h3C, 8, -1);
        spiDeselect();
        waitDrain("t4", base + 1);

        // Test 5: reset in the middle of a frame
        $display("[TB] test 5: mid-frame reset");
        base = beat_cnt;
        eb = bit_err_cnt;
        spiSelect();
        applyStimulus(8'hF0, 4, -1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("t5_rst_frame_active", 32'(frame_active), 32'd0);
        checkOutput("t5_rst_valid", 32'(rx_if.rx_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(8'h0F, 4, -1);
        applyStimulus(8'hAA, 8, -1);
        spiDeselect();
        waitDrain("t5_ignored", base);
        checkOutput("t5_bit_err", 32'(bit_err_cnt - eb), 32'd0);
        expectWord(1'b1, 8'h5A);
        spiSelect();
        applyStimulus(8'h5A, 8, -1);
        spiDeselect();
        waitDrain("t5", base + 1);

        // Test 6: 1-clk SCLK glitch before bit 3 of 0xC3
        $display("[TB] test 6: sclk glitch");
        base = beat_cnt;
        eb = bit_err_cnt;
        glitch_word = 8'hC3;
`ifdef SPI_SLAVE_RX_GLITCH_FILTER_EN
        gword = glitch_word;
        gbits = 0;
`else
        // The glitch samples the bit already on MOSI, so that bit is
        // captured twice; the ninth sample is a partial word.
        acc = '0;
        gbits = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                acc = {acc[14:0], glitch_word[7-i]};
                gbits++;
            end
            acc = {acc[14:0], glitch_word[7-i]};
            gbits++;
        end
        gword = acc[8:1];
        gbits = gbits - 8;
`endif
        expectWord(1'b1, gword);
        spiSelect();
        applyStimulus(glitch_word, 8, 3);
        spiDeselect();
        waitDrain("t6", base + 1);
        checkOutput("t6_bit_err", 32'(bit_err_cnt - eb), 32'(gbits));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
